// File: rtl/subterranean_lwc_segment_reader_if.sv
// Stream bundle between the LWC input buffer, the segment reader and the Subterranean core.
// Latency: n/a (wires only).
// Backpressure: din uses valid/ready from the buffer; dout uses valid/ready from the core.
//
// Signals:
//   din, din_valid, din_ready          word stream from the input buffer
//   dout, dout_valid, dout_ready       data word stream towards the core
//   dout_size, dout_last, dout_eot     byte count and segment/text end flags of dout
// Modports:
//   master  the segment reader (drives din_ready and the dout side)
//   slave   the environment (buffer + core)
interface subterranean_lwc_segment_reader_if #(
   parameter int G_WIDTH = 32
);
   logic [G_WIDTH-1:0] din;
   logic               din_valid;
   logic               din_ready;
   logic [G_WIDTH-1:0] dout;
   logic               dout_valid;
   logic               dout_ready;
   logic [2:0]         dout_size;
   logic               dout_last;
   logic               dout_eot;

   modport master (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, dout_size, dout_last, dout_eot
   );

   modport slave (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, dout_size, dout_last, dout_eot
   );
endinterface

// File: rtl/subterranean_lwc_segment_reader.sv
// Parses LWC segment headers and forwards the segment's data words with byte count and last/eot flags.
// Latency: data path is zero-latency pass-through; header fields and hdr_valid appear one cycle after acceptance.
// Backpressure: in data state din_ready follows dout_ready; headers are accepted whenever enabled.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   bus (master)       din/din_valid/din_ready in, dout/dout_valid/dout_ready/dout_size/dout_last/dout_eot out
//   enable             0 stalls both streams, state and byte counter hold
//   parser_rst         synchronous clear back to header parsing, wins over a same-cycle transfer
//   seg_*              fields of the most recently accepted header
//   hdr_valid          one-cycle pulse after a header is accepted
//   busy               1 while data words of a segment are outstanding
module subterranean_lwc_segment_reader #(
   parameter int G_WIDTH     = 32,
   parameter int G_LEN_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rstn,
   subterranean_lwc_segment_reader_if.master bus,
   input  logic                            enable,
   input  logic                            parser_rst,
   output logic [3:0]                      seg_type,
   output logic                            seg_partial,
   output logic                            seg_eoi,
   output logic                            seg_eot,
   output logic                            seg_last,
   output logic [G_LEN_WIDTH-1:0]          seg_len,
   output logic                            hdr_valid,
   output logic                            busy
);

   typedef enum logic {
      S_HDR  = 1'b0,
      S_DATA = 1'b1
   } state_t;

   state_t                 state;
   logic [G_LEN_WIDTH-1:0] rem;        // bytes of the current segment not yet forwarded
   logic                   in_data;
   logic [2:0]             size_c;
   logic                   last_c;
   logic [G_WIDTH-1:0]     keep_mask;
   logic                   hdr_xfer;
   logic                   beat;

   assign in_data = (state == S_DATA);

   // Size and last are forced to 0 outside the data state so every output is 0 while idle/reset.
   assign size_c = !in_data                   ? 3'd0 :
                   (rem >= G_LEN_WIDTH'(4))   ? 3'd4 : rem[2:0];
   assign last_c = in_data && (rem <= G_LEN_WIDTH'(4));

   // Bytes are MSB-first: keep the top size_c bytes. size 0 gives an all-zero mask, size 4 all ones.
   assign keep_mask = ~({G_WIDTH{1'b1}} >> {size_c, 3'b000});

   assign bus.din_ready  = rstn & enable & (in_data ? bus.dout_ready : 1'b1);
   assign bus.dout_valid = enable & in_data & bus.din_valid;
   assign bus.dout       = bus.din & keep_mask;
   assign bus.dout_size  = size_c;
   assign bus.dout_last  = last_c;
   assign bus.dout_eot   = last_c & seg_eot;
   assign busy           = in_data;

   assign hdr_xfer = enable & ~in_data & bus.din_valid;
   assign beat     = bus.dout_valid & bus.dout_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_HDR;
         rem         <= '0;
         seg_type    <= '0;
         seg_partial <= 1'b0;
         seg_eoi     <= 1'b0;
         seg_eot     <= 1'b0;
         seg_last    <= 1'b0;
         seg_len     <= '0;
         hdr_valid   <= 1'b0;
      end else if (parser_rst) begin
         // Any transfer handshaked in this cycle is dropped.
         state       <= S_HDR;
         rem         <= '0;
         seg_type    <= '0;
         seg_partial <= 1'b0;
         seg_eoi     <= 1'b0;
         seg_eot     <= 1'b0;
         seg_last    <= 1'b0;
         seg_len     <= '0;
         hdr_valid   <= 1'b0;
      end else begin
         hdr_valid <= 1'b0;
         if (state == S_HDR) begin
            if (hdr_xfer) begin
               seg_type    <= bus.din[31:28];
               seg_partial <= bus.din[27];
               seg_eoi     <= bus.din[26];
               seg_eot     <= bus.din[25];
               seg_last    <= bus.din[24];
               seg_len     <= bus.din[G_LEN_WIDTH-1:0];
               rem         <= bus.din[G_LEN_WIDTH-1:0];
               hdr_valid   <= 1'b1;
               // An empty segment has no data beats; the next word is another header.
               state       <= (bus.din[G_LEN_WIDTH-1:0] != '0) ? S_DATA : S_HDR;
            end
         end else begin
            if (beat) begin
               // size_c never exceeds rem, so this cannot wrap.
               rem <= rem - G_LEN_WIDTH'(size_c);
               if (last_c) begin
                  state <= S_HDR;
               end
            end
         end
      end
   end

endmodule
